// File: rtl/led_pwm_sequencer.sv
// Button-driven LED "breathing" sequencer: debounced commands drive a ramp FSM that steps
// the duty of a single PWM generator, which gates all LEDs together or one rotating LED.
module led_pwm_sequencer #(
    parameter int unsigned PWM_PERIOD = 200,
    parameter int unsigned DUTY_STEP  = 10,
    parameter int unsigned DB_CYCLES  = 150,
    parameter int unsigned DUTY_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        usr_btn,
    output logic [3:0]        usr_led,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_level,
    output logic [1:0]        fsm_state,
    output logic [1:0]        speed_idx
);
    localparam int unsigned       DbW       = $clog2(DB_CYCLES + 1);
    localparam logic [DbW-1:0]    DbMax     = DbW'(DB_CYCLES);
    localparam logic [DUTY_W-1:0] CntLast   = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W:0]   PeriodExt = (DUTY_W + 1)'(PWM_PERIOD);
    localparam logic [DUTY_W:0]   StepExt   = (DUTY_W + 1)'(DUTY_STEP);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StUp    = 2'b01,
        StDown  = 2'b10,
        StPause = 2'b11
    } state_e;

    logic [3:0]     sync1_q, sync2_q, cmd_q;
    logic [DbW-1:0] db_cnt_q [4];

    // cmd_q pulses for one cycle when a counter steps from DB_CYCLES-1 to DB_CYCLES.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cmd_q   <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= usr_btn;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                if (!sync2_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] != DbMax) begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
                cmd_q[i] <= sync2_q[i] && (db_cnt_q[i] == DbMax - 1'b1);
            end
        end
    end

    state_e            state_q, state_d;
    logic              dir_up_q, dir_up_d;
    logic [DUTY_W-1:0] duty_q, duty_d, shadow_q, shadow_d, pwm_cnt_q, pwm_cnt_d;
    logic              pwm_q, pwm_d;
    logic [1:0]        speed_q, speed_d;
    logic              chase_q, chase_d;
    logic [3:0]        mask_q, mask_d;
    logic [3:0]        step_cnt_q, step_cnt_d, step_cnt_inc, step_len;
    logic              tick, step_evt;
    logic [DUTY_W:0]   duty_ext, duty_sum, duty_up, duty_dn;

    always_comb begin
        state_d      = state_q;
        dir_up_d     = dir_up_q;
        duty_d       = duty_q;
        step_cnt_d   = step_cnt_q;
        speed_d      = speed_q;
        chase_d      = chase_q;
        mask_d       = mask_q;
        step_evt     = 1'b0;
        tick         = (pwm_cnt_q == CntLast);
        step_len     = 4'd1 << speed_q;
        step_cnt_inc = step_cnt_q + 4'd1;
        duty_ext     = {1'b0, duty_q};
        duty_sum     = duty_ext + StepExt;
        duty_up      = (duty_sum > PeriodExt) ? PeriodExt : duty_sum;
        duty_dn      = (duty_ext >= StepExt) ? duty_ext - StepExt : '0;

        // ">=" lets a speed-up issue the pending step on the very next period tick.
        if ((state_q == StUp || state_q == StDown) && tick) begin
            if (step_cnt_inc >= step_len) begin
                step_evt   = 1'b1;
                step_cnt_d = '0;
            end else begin
                step_cnt_d = step_cnt_inc;
            end
        end

        unique case (state_q)
            StIdle: begin
                duty_d = '0;
                if (cmd_q[0]) begin
                    state_d    = StUp;
                    step_cnt_d = '0;
                end
            end
            StUp: begin
                if (cmd_q[0]) begin
                    state_d    = StPause;
                    dir_up_d   = 1'b1;
                    step_cnt_d = step_cnt_q;
                end else if (step_evt) begin
                    if (duty_ext == PeriodExt) begin
                        state_d = StDown;
                        duty_d  = duty_dn[DUTY_W-1:0];
                    end else begin
                        duty_d  = duty_up[DUTY_W-1:0];
                    end
                end
            end
            StDown: begin
                if (cmd_q[0]) begin
                    state_d    = StPause;
                    dir_up_d   = 1'b0;
                    step_cnt_d = step_cnt_q;
                end else if (step_evt) begin
                    if (duty_q == '0) begin
                        state_d = StUp;
                        duty_d  = duty_up[DUTY_W-1:0];
                        if (chase_q) mask_d = {mask_q[2:0], mask_q[3]};
                    end else begin
                        duty_d  = duty_dn[DUTY_W-1:0];
                    end
                end
            end
            StPause: begin
                if (cmd_q[0]) state_d = dir_up_q ? StUp : StDown;
            end
        endcase

        if (cmd_q[1]) begin
            chase_d = ~chase_q;
            if (!chase_q) mask_d = 4'b0001;
        end
        if (cmd_q[2] && !cmd_q[3] && speed_q != 2'd0) begin
            speed_d = speed_q - 2'd1;
        end else if (cmd_q[3] && !cmd_q[2] && speed_q != 2'd3) begin
            speed_d = speed_q + 2'd1;
        end

        // Shadow takes the post-step duty so a step shows from the first cycle of the new period.
        pwm_cnt_d = tick ? '0 : pwm_cnt_q + 1'b1;
        shadow_d  = tick ? duty_d : shadow_q;
        pwm_d     = (pwm_cnt_d < shadow_d);
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q    <= StIdle;
            dir_up_q   <= 1'b1;
            duty_q     <= '0;
            shadow_q   <= '0;
            pwm_cnt_q  <= '0;
            pwm_q      <= 1'b0;
            speed_q    <= 2'd2;
            chase_q    <= 1'b0;
            mask_q     <= 4'b0001;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_up_q   <= dir_up_d;
            duty_q     <= duty_d;
            shadow_q   <= shadow_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_q      <= pwm_d;
            speed_q    <= speed_d;
            chase_q    <= chase_d;
            mask_q     <= mask_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign usr_led    = chase_q ? (mask_q & {4{pwm_q}}) : {4{pwm_q}};
    assign duty_level = duty_q;
    assign fsm_state  = state_q;
    assign speed_idx  = speed_q;

endmodule

// File: doc/led_pwm_sequencer.md
# led_pwm_sequencer

Autonomous LED brightness sequencer for the user-LED/PWM path. It debounces the four user pushbuttons into command pulses and runs a ramp FSM that steps a PWM duty level up and down ("breathing"). The FSM owns a single PWM generator, gates the four LEDs with it, and can either drive all LEDs together or rotate one lit LED per breath cycle ("chase").

## Interface
- PWM_PERIOD, 200, clock cycles per PWM period
- DUTY_STEP, 10, duty increment/decrement per ramp step, in clock cycles of high time
- DB_CYCLES, 150, consecutive synchronized-high cycles needed to accept a button press
- DUTY_W, 8, width of duty/counter registers; must hold PWM_PERIOD (≥ $clog2(PWM_PERIOD+1))

- clk  in  1  system clock, 100 MHz
- reset_n  in  1  synchronous, active-high reset. The name is kept for consistency; the polarity is active-high.
- usr_btn  in  4  raw pushbuttons: [0] run/pause, [1] mode toggle, [2] faster, [3] slower
- usr_led  out  4  LED drive, PWM-gated
- pwm_out  out  1  PWM waveform
- duty_level  out  DUTY_W  current FSM duty target
- fsm_state  out  2  00 IDLE, 01 UP, 10 DOWN, 11 PAUSE
- speed_idx  out  2  current step-length index

## Operation
- **Reset values:** fsm_state IDLE, duty_level 0, shadow duty 0, pwm counter 0, pwm_out 0, usr_led 0, speed_idx 2, mode breathe, led_mask 0001, step counter 0, all debounce counters 0, paused-direction UP.
- **Button front end:**
  - Each bit passes through a 2-flop synchronizer.
  - Each debounce counter increments while its synchronized input is high, clears when it is low, and saturates at DB_CYCLES.
  - A one-cycle command pulse fires when the counter reaches DB_CYCLES. There is exactly one pulse per press, and none while the button is held.
- **PWM generator:**
  - Counter runs 0..PWM_PERIOD-1 and wraps to 0.
  - pwm_out = (counter < shadow duty), so duty 0 is constant low and duty PWM_PERIOD is constant high.
  - The shadow duty loads duty_level when counter = PWM_PERIOD-1 (period tick). Duty never changes mid-period.
- **Step timing:**
  - step_len = 1 << speed_idx periods (1, 2, 4, 8).
  - The step counter counts period ticks in UP and DOWN only.
  - When it reaches step_len it issues a step event and clears.
- **FSM:**
  - IDLE: duty_level held 0. btn0 → UP with step counter cleared.
  - UP: on a step event, duty_level += DUTY_STEP, saturating at PWM_PERIOD. Once duty_level equals PWM_PERIOD, the next step event moves the FSM to DOWN and decrements duty.
  - DOWN: on a step event, duty_level -= DUTY_STEP, floored at 0. Once it equals 0, the next step event moves the FSM to UP, increments duty, and (chase mode only) rotates led_mask left (1000 → 0001).
  - UP/DOWN + btn0 → PAUSE, saving the direction. Duty and step counter freeze; PWM keeps running.
  - PAUSE + btn0 → the saved direction.
- **Other commands:**
  - btn1 toggles mode in any state. Entering chase loads led_mask 0001.
  - btn2: speed_idx -= 1, saturating at 0.
  - btn3: speed_idx += 1, saturating at 3.
  - A speed change takes effect from the next step count and does not clear the step counter. If the count already meets or exceeds the new step_len, the next period tick issues a step event.
- **LED output:** breathe mode usr_led = {4{pwm_out}}; chase mode usr_led = led_mask & {4{pwm_out}}. IDLE forces duty 0, so LEDs are dark.
- **Simultaneous events:**
  - All pulses in the same cycle are applied independently.
  - btn2 and btn3 together → speed_idx unchanged.
  - btn0 together with a step event → the btn0 transition wins and the step is discarded.
  - Reset asserted mid-ramp or mid-debounce restores all reset values on that edge, regardless of other inputs.

## Timing
- **Button latency:** a raw press held steady produces its register effect (fsm_state, speed_idx, mode) at edge DB_CYCLES+3 ±0 after the first cycle the raw input is sampled high: 2 sync + DB_CYCLES count + 1 update.
- **Duty to PWM:** a duty_level change at a step event is visible on pwm_out from the first cycle of the next PWM period.
- **Step rate:** duty_level changes exactly every step_len × PWM_PERIOD cycles while running.
- **Outputs:** all outputs are registered. pwm_out and usr_led change only on clk edges; usr_led is combinational only from registered pwm_out and led_mask.

## Test plan
Bench parameters: PWM_PERIOD=20, DUTY_STEP=5, DB_CYCLES=4.

- **Reset defaults:** reset 3 cycles, then idle 100 cycles → fsm_state 00, duty_level 0, pwm_out 0, usr_led 0000, speed_idx 2.
- **Debounce and start:**
  - A 3-cycle btn0 glitch produces no change.
  - A steady btn0 press produces fsm_state 01 exactly 7 cycles after the first high sample.
  - Holding btn0 for 200 cycles gives no further toggle.
- **Ramp:**
  - Running at speed_idx 0, duty_level goes 5, 10, 15, 20, then 15, …, 0, then 5, changing every 20 cycles.
  - pwm_out high for exactly duty cycles per period.
  - At duty 20 pwm_out is high all period; at duty 0 it is low all period.
- **Pause/resume:**
  - btn0 during DOWN at duty 10 → fsm_state 11; duty stays 10 for 500 cycles while pwm_out keeps a 10/20 waveform.
  - btn0 again → 10, and the next step gives duty 5.
- **Chase:**
  - btn1 gives led_mask 0001, with usr_led = 000x gated by pwm_out.
  - Each return of duty to 0 followed by the next step rotates the mask 0010 → 0100 → 1000 → 0001.
- **Speed saturation and simultaneity:**
  - Three btn3 presses leave speed_idx 3, with steps every 160 cycles.
  - btn2 and btn3 pulsed together leave speed_idx unchanged.
  - Reset asserted mid-UP returns all reset values on the next edge.
